// File: rtl/axi_burst_reader_pkg.sv
// Shared AXI read types: size/burst/response enums, read-control and status
// structs, response-priority merge and the 4 KB boundary constant.
package axi_burst_reader_pkg;

  localparam int unsigned BOUNDARY_4K = 4096;

  typedef enum logic [2:0] {
    SIZE_1B   = 3'd0,
    SIZE_2B   = 3'd1,
    SIZE_4B   = 3'd2,
    SIZE_8B   = 3'd3,
    SIZE_16B  = 3'd4,
    SIZE_32B  = 3'd5,
    SIZE_64B  = 3'd6,
    SIZE_128B = 3'd7
  } axi_size_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPLIT = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_DONE  = 3'd4
  } rd_state_e;

  typedef struct packed {
    logic [31:0] address;
    logic [15:0] bytes;
  } rd_ctrl_t;

  typedef struct packed {
    logic      done;
    axi_resp_e resp;
  } rd_status_t;

  function automatic logic [1:0] resp_rank(input axi_resp_e r);
    case (r)
      RESP_OKAY:   return 2'd0;
      RESP_EXOKAY: return 2'd1;
      RESP_SLVERR: return 2'd2;
      RESP_DECERR: return 2'd3;
      default:     return 2'd0;
    endcase
  endfunction

  // Sticky merge: keep whichever response carries the higher priority.
  function automatic axi_resp_e resp_merge(input axi_resp_e a, input axi_resp_e b);
    return (resp_rank(b) > resp_rank(a)) ? b : a;
  endfunction

  function automatic axi_size_e size_of(input int unsigned data_w);
    case (data_w)
      32'd8:    return SIZE_1B;
      32'd16:   return SIZE_2B;
      32'd32:   return SIZE_4B;
      32'd64:   return SIZE_8B;
      32'd128:  return SIZE_16B;
      32'd256:  return SIZE_32B;
      32'd512:  return SIZE_64B;
      32'd1024: return SIZE_128B;
      default:  return SIZE_8B;
    endcase
  endfunction

endpackage

// File: rtl/axi_burst_reader_if.sv
// Request, AR/R and output-stream signals of the burst reader; master is the
// reader's view, slave is the surrounding system's view.
interface axi_burst_reader_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  import axi_burst_reader_pkg::*;

  logic              ctrl_valid;
  logic              ctrl_ready;
  rd_ctrl_t          ctrl;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
  logic              done;
  logic [1:0]        status;

  modport master (
    input  ctrl_valid, ctrl, arready, rdata, rresp, rlast, rvalid, out_ready,
    output ctrl_ready, araddr, arlen, arsize, arburst, arvalid, rready,
           out_data, out_last, out_valid, done, status
  );

  modport slave (
    output ctrl_valid, ctrl, arready, rdata, rresp, rlast, rvalid, out_ready,
    input  ctrl_ready, araddr, arlen, arsize, arburst, arvalid, rready,
           out_data, out_last, out_valid, done, status
  );
endinterface

// File: rtl/axi_burst_reader_splitter.sv
// Combinational burst sizing: min(remaining beats, MAX_BEATS, beats to the
// next 4 KB boundary). The address is beat-aligned, so the division is exact.
module axi_burst_splitter
  import axi_burst_reader_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 256
) (
  input  logic [11:0] i_addr_lo,
  input  logic [16:0] i_remaining,
  output logic [8:0]  o_beats
);
  localparam int SZ = $clog2(DATA_W / 8);

  logic [12:0] w_to_4k_bytes;
  logic [12:0] w_to_4k_beats;
  logic [8:0]  w_cap;

  assign w_to_4k_bytes = 13'(BOUNDARY_4K) - {1'b0, i_addr_lo};
  assign w_to_4k_beats = w_to_4k_bytes >> SZ;
  assign w_cap   = (w_to_4k_beats < 13'(MAX_BEATS)) ? w_to_4k_beats[8:0] : 9'(MAX_BEATS);
  assign o_beats = (i_remaining < {8'd0, w_cap}) ? i_remaining[8:0] : w_cap;
endmodule

// File: rtl/axi_burst_reader.sv
// AXI4 read master: splits one (address, bytes) request into INCR bursts,
// streams beats downstream and reports one sticky completion status.
module axi_burst_reader
  import axi_burst_reader_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 256
) (
  input logic               clk,
  input logic               rst_n,
  axi_burst_reader_if.master bus
);
  localparam int BEAT_BYTES = DATA_W / 8;
  localparam int SZ         = $clog2(BEAT_BYTES);

  rd_state_e         r_state;
  rd_state_e         w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic [16:0]       r_remain;
  logic [8:0]        r_burst_cnt;
  axi_resp_e         r_status;

  logic        w_accept;
  logic        w_zero;
  logic        w_misaligned;
  logic [16:0] w_req_beats;
  logic        w_beat;
  logic        w_burst_end;
  logic        w_rlast_err;
  axi_resp_e   w_beat_resp;
  logic [8:0]  w_beats;

  assign w_accept     = bus.ctrl_valid && (r_state == ST_IDLE);
  assign w_zero       = (bus.ctrl.bytes == 16'd0);
  assign w_misaligned = (bus.ctrl.address & 32'(BEAT_BYTES - 1)) != 32'd0;
  assign w_req_beats  = ({1'b0, bus.ctrl.bytes} + 17'(BEAT_BYTES - 1)) >> SZ;
  assign w_beat       = (r_state == ST_DATA) && bus.rvalid && bus.out_ready;
  assign w_burst_end  = (r_burst_cnt == 9'd1);
  // The beat counter ends the burst; rlast is only checked against it.
  assign w_rlast_err  = (bus.rlast != w_burst_end);
  assign w_beat_resp  = resp_merge(axi_resp_e'(bus.rresp), w_rlast_err ? RESP_SLVERR : RESP_OKAY);

  axi_burst_splitter #(
    .DATA_W    (DATA_W),
    .MAX_BEATS (MAX_BEATS)
  ) u_splitter (
    .i_addr_lo   (r_addr[11:0]),
    .i_remaining (r_remain),
    .o_beats     (w_beats)
  );

  assign bus.ctrl_ready = (r_state == ST_IDLE);
  assign bus.arvalid    = (r_state == ST_ADDR);
  assign bus.araddr     = r_araddr;
  assign bus.arlen      = r_arlen;
  assign bus.arsize     = size_of(DATA_W);
  assign bus.arburst    = BURST_INCR;
  assign bus.rready     = (r_state == ST_DATA) && bus.out_ready;
  assign bus.out_valid  = (r_state == ST_DATA) && bus.rvalid;
  assign bus.out_data   = bus.rdata;
  assign bus.out_last   = bus.out_valid && (r_remain == 17'd1);
  assign bus.done       = (r_state == ST_DONE);
  assign bus.status     = r_status;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = (w_zero || w_misaligned) ? ST_DONE : ST_SPLIT;
        else          w_next = ST_IDLE;
      end
      ST_SPLIT: w_next = ST_ADDR;
      ST_ADDR: begin
        if (bus.arready) w_next = ST_DATA;
        else             w_next = ST_ADDR;
      end
      ST_DATA: begin
        if (w_beat && w_burst_end) w_next = (r_remain > 17'd1) ? ST_SPLIT : ST_DONE;
        else                       w_next = ST_DATA;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Request bookkeeping, AR payload and status accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_araddr    <= '0;
      r_arlen     <= 8'd0;
      r_remain    <= 17'd0;
      r_burst_cnt <= 9'd0;
      r_status    <= RESP_OKAY;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr   <= ADDR_W'(bus.ctrl.address);
            r_remain <= w_req_beats;
            r_status <= (!w_zero && w_misaligned) ? RESP_SLVERR : RESP_OKAY;
          end
        end
        ST_SPLIT: begin
          r_araddr    <= r_addr;
          r_arlen     <= 8'(w_beats - 9'd1);
          r_burst_cnt <= w_beats;
        end
        ST_DATA: begin
          if (w_beat) begin
            r_burst_cnt <= r_burst_cnt - 9'd1;
            r_remain    <= r_remain - 17'd1;
            r_addr      <= r_addr + ADDR_W'(BEAT_BYTES);
            r_status    <= resp_merge(r_status, w_beat_resp);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
